// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic psum drain path.
//   drain_state_e : drain FSM states (IDLE, CAPT, WAIT, DRAIN)
//   DEF_PSUM_W    : default column psum width
//   DEF_ACC_W     : default accumulator / result width
//   col_w()       : width of a column index for an array of n columns
//                   (never less than one bit so that 1-column arrays still
//                   have a legal index vector)
// -----------------------------------------------------------------------------
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CAPT  = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } drain_state_e;

   localparam int DEF_PSUM_W = 32;
   localparam int DEF_ACC_W  = 40;

   function automatic int col_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/psum_shift_acc.sv
// -----------------------------------------------------------------------------
// psum_shift_acc
// One accumulator lane: sign-extends a column psum, shifts it left by the
// bit-slice weight and adds it to the running accumulator. Purely
// combinational; the caller owns the accumulator register.
// Optional feature macro: PSUM_SATURATE_EN (saturating add to the signed
// ACC_W range instead of modulo-2^ACC_W wrap).
//   en_i    in  1       lane is capturing this cycle (otherwise sum_o = acc_i)
//   acc_i   in  ACC_W   current accumulator value
//   psum_i  in  PSUM_W  signed column psum
//   shift_i in  4       left shift applied to the psum
//   sum_o   out ACC_W   next accumulator value
// ACC_W is expected to be wider than PSUM_W.
// -----------------------------------------------------------------------------
module psum_shift_acc #(
   parameter int PSUM_W = 32,
   parameter int ACC_W  = 40
) (
   input  logic              en_i,
   input  logic [ACC_W-1:0]  acc_i,
   input  logic [PSUM_W-1:0] psum_i,
   input  logic [3:0]        shift_i,
   output logic [ACC_W-1:0]  sum_o
);

`ifdef PSUM_SATURATE_EN
   // Wide enough to hold the largest shifted psum plus the accumulator
   // without losing any bit, so overflow can be judged exactly.
   localparam int WW = ((ACC_W > PSUM_W) ? ACC_W : PSUM_W) + 17;

   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [WW-1:0]    addend_w;
   logic [WW-1:0]    acc_w;
   logic [WW-1:0]    sum_w;
   logic             addend_fits;
   logic             sum_fits;
   logic [ACC_W-1:0] result;

   // A wide value fits the signed ACC_W range when every bit from the ACC_W
   // sign bit upward is a copy of it.
   function automatic logic fits_acc(input logic [WW-1:0] x);
      return (x[WW-1:ACC_W-1] == '0) || (x[WW-1:ACC_W-1] == '1);
   endfunction

   always_comb begin
      addend_w    = {{(WW-PSUM_W){psum_i[PSUM_W-1]}}, psum_i} << shift_i;
      acc_w       = {{(WW-ACC_W){acc_i[ACC_W-1]}}, acc_i};
      sum_w       = acc_w + addend_w;
      addend_fits = fits_acc(addend_w);
      sum_fits    = fits_acc(sum_w);
      // A shifted addend that already left the range saturates in its own
      // direction regardless of the accumulator contents.
      if (!addend_fits) begin
         result = addend_w[WW-1] ? SAT_MIN : SAT_MAX;
      end else if (!sum_fits) begin
         result = sum_w[WW-1] ? SAT_MIN : SAT_MAX;
      end else begin
         result = sum_w[ACC_W-1:0];
      end
      sum_o = en_i ? result : acc_i;
   end
`else
   logic [ACC_W-1:0] addend;

   // Shifting within ACC_W bits discards anything pushed past the top,
   // which is exactly modulo-2^ACC_W behaviour.
   always_comb begin
      addend = {{(ACC_W-PSUM_W){psum_i[PSUM_W-1]}}, psum_i} << shift_i;
      sum_o  = en_i ? (acc_i + addend) : acc_i;
   end
`endif

endmodule

// File: rtl/systolic_psum_drain.sv
// -----------------------------------------------------------------------------
// systolic_psum_drain
// Collects the diagonally skewed column psums of the systolic array,
// shift-accumulates successive bit-slice passes and streams the finished row
// out one column per valid/ready handshake.
// Optional feature macro: PSUM_SATURATE_EN (saturating accumulation).
//   clk        in  1                 rising-edge clock
//   rst        in  1                 asynchronous active-low reset
//   psums      in  ARRAY_SIZE*PSUM_W column c at [c*PSUM_W +: PSUM_W]
//   row_start  in  1                 column 0 of a pass valid this cycle
//   row_shift  in  4                 pass shift, sampled with row_start
//   row_last   in  1                 pass completes the row
//   accept     out 1                 row_start is honoured this cycle
//   drop       out 1                 registered pulse for an ignored row_start
//   out_valid  out 1                 out_data valid
//   out_ready  in  1                 downstream accepts the word
//   out_data   out ACC_W             accumulated result of column out_col
//   out_col    out col_w(ARRAY_SIZE) column index of out_data
//   out_last   out 1                 out_col is the final column
// -----------------------------------------------------------------------------
module systolic_psum_drain
   import systolic_pkg::*;
#(
   parameter int ARRAY_SIZE = 8,
   parameter int PSUM_W     = DEF_PSUM_W,
   parameter int ACC_W      = DEF_ACC_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ARRAY_SIZE*PSUM_W-1:0] psums,
   input  logic                         row_start,
   input  logic [3:0]                   row_shift,
   input  logic                         row_last,
   output logic                         accept,
   output logic                         drop,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_W-1:0]             out_data,
   output logic [col_w(ARRAY_SIZE)-1:0] out_col,
   output logic                         out_last
);

   localparam int            CW       = col_w(ARRAY_SIZE);
   localparam logic [CW-1:0] LAST_COL = CW'(ARRAY_SIZE - 1);

   drain_state_e     state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    idx_q, idx_d;
   logic [3:0]       shift_q, shift_d;
   logic             last_q, last_d;

   logic [ACC_W-1:0] acc_q    [ARRAY_SIZE];
   logic [ACC_W-1:0] acc_d    [ARRAY_SIZE];
   logic [ACC_W-1:0] lane_sum [ARRAY_SIZE];
   logic [ARRAY_SIZE-1:0] lane_en;

   logic             cap_en;
   logic [CW-1:0]    cap_col;
   logic [3:0]       cur_shift;
   logic             clr;

   logic             accept_q, accept_d;
   logic             drop_q, drop_d;
   logic             out_valid_q, out_valid_d;
   logic [ACC_W-1:0] out_data_q, out_data_d;
   logic [CW-1:0]    out_col_q, out_col_d;
   logic             out_last_q, out_last_d;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      last_d    = last_q;
      cap_en    = 1'b0;
      cap_col   = cnt_q;
      cur_shift = shift_q;
      clr       = 1'b0;
      drop_d    = 1'b0;

      unique case (state_q)
         IDLE, WAIT: begin
            if (row_start) begin
               // Column 0 arrives together with row_start, so it uses the
               // live shift rather than the latched one.
               cap_en    = 1'b1;
               cap_col   = '0;
               cur_shift = row_shift;
               shift_d   = row_shift;
               last_d    = row_last;
               if (ARRAY_SIZE == 1) begin
                  cnt_d   = '0;
                  state_d = row_last ? DRAIN : WAIT;
               end else begin
                  cnt_d   = CW'(1);
                  state_d = CAPT;
               end
            end
         end
         CAPT: begin
            cap_en = 1'b1;
            drop_d = row_start;
            if (cnt_q == LAST_COL) begin
               cnt_d   = '0;
               state_d = last_q ? DRAIN : WAIT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DRAIN: begin
            drop_d = row_start;
            // out_valid is always high in DRAIN, so out_ready alone is the
            // handshake.
            if (out_ready) begin
               if (idx_q == LAST_COL) begin
                  idx_d   = '0;
                  clr     = 1'b1;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + CW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // --------------------------------------------------------- accumulators
   for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
      assign lane_en[gi] = cap_en && (cap_col == CW'(gi));

      psum_shift_acc #(
         .PSUM_W (PSUM_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .en_i    (lane_en[gi]),
         .acc_i   (acc_q[gi]),
         .psum_i  (psums[gi*PSUM_W +: PSUM_W]),
         .shift_i (cur_shift),
         .sum_o   (lane_sum[gi])
      );

      assign acc_d[gi] = clr ? '0 : lane_sum[gi];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            acc_q[gi] <= '0;
         end else begin
            acc_q[gi] <= acc_d[gi];
         end
      end
   end

   // ------------------------------------------------------ output next-state
   // Outputs are computed from next-state values so they are registered yet
   // line up with the state they describe.
   always_comb begin
      accept_d    = (state_d == IDLE) || (state_d == WAIT);
      out_valid_d = (state_d == DRAIN);
      out_data_d  = '0;
      out_col_d   = '0;
      out_last_d  = 1'b0;
      if (state_d == DRAIN) begin
         out_data_d = acc_d[idx_d];
         out_col_d  = idx_d;
         out_last_d = (idx_d == LAST_COL);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         last_q      <= 1'b0;
         accept_q    <= 1'b1;
         drop_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_col_q   <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         last_q      <= last_d;
         accept_q    <= accept_d;
         drop_q      <= drop_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_col_q   <= out_col_d;
         out_last_q  <= out_last_d;
      end
   end

   assign accept    = accept_q;
   assign drop      = drop_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_col   = out_col_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_systolic_psum_drain.sv
// -----------------------------------------------------------------------------
// tb_systolic_psum_drain
// Directed stimulus for a 4-column drain. Expected result words are queued
// when a last pass is issued; a monitor pops and compares on every output
// handshake.
// -----------------------------------------------------------------------------
module tb_systolic_psum_drain;

   localparam int N      = 4;
   localparam int PSUM_W = 32;
   localparam int ACC_W  = 40;
   localparam logic [PSUM_W-1:0] JUNK = 32'hA5A5_1234;

   typedef struct {
      logic [ACC_W-1:0] data;
      logic [1:0]       col;
      logic             last;
   } exp_t;

   logic                   clk = 1'b0;
   logic                   rst = 1'b0;
   logic [N*PSUM_W-1:0]    psums = '0;
   logic                   row_start = 1'b0;
   logic [3:0]             row_shift = '0;
   logic                   row_last = 1'b0;
   logic                   accept;
   logic                   drop;
   logic                   out_valid;
   logic                   out_ready = 1'b1;
   logic [ACC_W-1:0]       out_data;
   logic [1:0]             out_col;
   logic                   out_last;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   systolic_psum_drain #(
      .ARRAY_SIZE (N),
      .PSUM_W     (PSUM_W),
      .ACC_W      (ACC_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .psums     (psums),
      .row_start (row_start),
      .row_shift (row_shift),
      .row_last  (row_last),
      .accept    (accept),
      .drop      (drop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_col   (out_col),
      .out_last  (out_last)
   );

   task automatic check(input string name, input logic [ACC_W-1:0] act,
                        input logic [ACC_W-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         exp_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word: got col %0d data %h, expected none",
                     out_col, out_data);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e.data || out_col !== e.col || out_last !== e.last) begin
               errors++;
               $display("FAIL word: got col %0d data %h last %b expected col %0d data %h last %b",
                        out_col, out_data, out_last, e.col, e.data, e.last);
            end else begin
               $display("word col %0d data %h last %b ok", out_col, out_data, out_last);
            end
         end
      end
   end

   task automatic push_row(input logic [ACC_W-1:0] d0, d1, d2, d3);
      exp_t e;
      e.data = d0; e.col = 2'd0; e.last = 1'b0; exp_q.push_back(e);
      e.data = d1; e.col = 2'd1; e.last = 1'b0; exp_q.push_back(e);
      e.data = d2; e.col = 2'd2; e.last = 1'b0; exp_q.push_back(e);
      e.data = d3; e.col = 2'd3; e.last = 1'b1; exp_q.push_back(e);
   endtask

   // Drives one skewed pass. Entered 1 ns after an edge; column t is sampled
   // at the t-th following edge. Returns 1 ns after the last column's edge.
   task automatic run_pass(input logic [PSUM_W-1:0] v0, v1, v2, v3,
                           input logic [3:0] sh, input logic lst,
                           input int drop_t, input bit chk);
      logic [PSUM_W-1:0] v [N];
      v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
      for (int t = 0; t < N; t++) begin
         psums = {N{JUNK}};
         psums[t*PSUM_W +: PSUM_W] = v[t];
         row_start = (t == 0) || (t == drop_t);
         row_shift = (t == 0) ? sh : 4'hF;
         row_last  = (t == 0) ? lst : ~lst;
         @(posedge clk); #1;
         if (chk) begin
            check($sformatf("drop_t%0d", t), ACC_W'(drop), ACC_W'(t == drop_t && t > 0));
            check($sformatf("accept_t%0d", t), ACC_W'(accept), ACC_W'((t == N-1) && !lst));
            check($sformatf("valid_t%0d", t), ACC_W'(out_valid), ACC_W'((t == N-1) && lst));
         end
      end
      psums     = {N{JUNK}};
      row_start = 1'b0;
      row_shift = 4'hF;
      row_last  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_drained"}, ACC_W'(n < 50), ACC_W'(1));
      check({name, "_accept"}, ACC_W'(accept), ACC_W'(1));
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_accept"}, ACC_W'(accept), ACC_W'(1));
      check({name, "_drop"}, ACC_W'(drop), '0);
      check({name, "_valid"}, ACC_W'(out_valid), '0);
      check({name, "_data"}, out_data, '0);
      check({name, "_col"}, ACC_W'(out_col), '0);
      check({name, "_last"}, ACC_W'(out_last), '0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check_reset_outputs("rst_held");
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("rst_released");

      // 1: single pass, psums 1..4, timing checked inside the pass
      push_row(40'd1, 40'd2, 40'd3, 40'd4);
      run_pass(32'd1, 32'd2, 32'd3, 32'd4, 4'd0, 1'b1, -1, 1'b1);
      $display("single pass issued");
      wait_idle("single");

      // 2: two passes back-to-back from WAIT: 3 + (-1 << 4) = -13
      run_pass(32'd3, 32'd3, 32'd3, 32'd3, 4'd0, 1'b0, -1, 1'b1);
      check("wait_accept", ACC_W'(accept), ACC_W'(1));
      push_row(40'hFF_FFFF_FFF3, 40'hFF_FFFF_FFF3, 40'hFF_FFFF_FFF3, 40'hFF_FFFF_FFF3);
      run_pass(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               4'd4, 1'b1, -1, 1'b1);
      $display("two pass issued");
      wait_idle("two_pass");

      // 3: backpressure
      out_ready = 1'b0;
      push_row(40'd10, 40'd20, 40'd30, 40'd40);
      run_pass(32'd10, 32'd20, 32'd30, 32'd40, 4'd0, 1'b1, -1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", ACC_W'(out_valid), ACC_W'(1));
         check("bp_col0", ACC_W'(out_col), '0);
         check("bp_data0", out_data, 40'd10);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         check("bp_col2", ACC_W'(out_col), ACC_W'(2));
         check("bp_data2", out_data, 40'd30);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      $display("backpressure issued");
      wait_idle("backpressure");

      // 4: row_start during CAPT and during DRAIN
      out_ready = 1'b0;
      push_row(40'd7, 40'd8, 40'd9, 40'd11);
      run_pass(32'd7, 32'd8, 32'd9, 32'd11, 4'd0, 1'b1, 2, 1'b1);
      row_start = 1'b1;
      row_shift = 4'd0;
      row_last  = 1'b1;
      @(posedge clk); #1;
      row_start = 1'b0;
      check("drain_drop", ACC_W'(drop), ACC_W'(1));
      @(posedge clk); #1;
      check("drain_drop_clear", ACC_W'(drop), '0);
      check("drain_col", ACC_W'(out_col), '0);
      check("drain_data", out_data, 40'd7);
      out_ready = 1'b1;
      $display("protocol violation issued");
      wait_idle("protocol");

      // 5: reset mid-CAPT, with residue left in WAIT first
      run_pass(32'd100, 32'd100, 32'd100, 32'd100, 4'd0, 1'b0, -1, 1'b0);
      psums     = {N{JUNK}};
      psums[0 +: PSUM_W] = 32'd100;
      row_start = 1'b1;
      row_shift = 4'd0;
      row_last  = 1'b1;
      @(posedge clk); #1;
      row_start = 1'b0;
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check_reset_outputs("rst_mid_capt");
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      push_row(40'd5, 40'd6, 40'd7, 40'd8);
      run_pass(32'd5, 32'd6, 32'd7, 32'd8, 4'd0, 1'b1, -1, 1'b0);
      $display("post-reset pass issued");
      wait_idle("post_reset");

      // 6: 0x7FFFFFFF << 15, accumulated twice
      run_pass(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
               4'd15, 1'b0, -1, 1'b0);
`ifdef PSUM_SATURATE_EN
      push_row(40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFF, 40'h7F_FFFF_FFFF);
`else
      push_row(40'hFF_FFFF_0000, 40'hFF_FFFF_0000, 40'hFF_FFFF_0000, 40'hFF_FFFF_0000);
`endif
      run_pass(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
               4'd15, 1'b1, -1, 1'b0);
      $display("shift overflow pass issued");
      wait_idle("overflow");

      check("queue_empty", ACC_W'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/systolic_psum_drain.md
# systolic_psum_drain

Output-side collector for the bit-fusion systolic array. Captures the diagonally skewed per-column partial sums leaving the array, shift-accumulates successive bit-slice passes into full-precision results, and streams the finished row out one column per handshake. Sits between the array's `psums` bus and the result writeback path. It is the receive end of the interface the array feeds.

## Interface
Parameters:
- `ARRAY_SIZE`, 8: number of array columns, which is also the number of result words per row.
- `PSUM_W`, 32: width of one column psum.
- `ACC_W`, 40: accumulator and output width.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `psums`  in  ARRAY_SIZE*PSUM_W  column c at `[c*PSUM_W +: PSUM_W]`, signed two's complement.
- `row_start`  in  1  column 0 of a pass is valid this cycle; column c is valid c cycles later.
- `row_shift`  in  4  left-shift for this pass (bit-slice weight); sampled with `row_start`.
- `row_last`  in  1  this pass completes the row; sampled with `row_start`.
- `accept`  out  1  `row_start` is honoured this cycle.
- `drop`  out  1  one-cycle pulse when `row_start` arrives while `accept`=0.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  ACC_W  accumulated result for column `out_col`.
- `out_col`  out  clog2(ARRAY_SIZE)  column index of `out_data`.
- `out_last`  out  1  `out_col` == ARRAY_SIZE-1 while `out_valid`.

## Operation
- State machine with four states.
  - IDLE: accumulators are zero and `accept`=1. On `row_start`: capture column 0, latch the shift and last flags, set cnt=1, go to CAPT. If ARRAY_SIZE=1, go straight to DRAIN or WAIT.
  - CAPT: capture column cnt each cycle and increment cnt. When column ARRAY_SIZE-1 is captured, go to DRAIN if the latched last flag is set, else go to WAIT. `accept`=0.
  - WAIT: `accept`=1 and accumulators are held. `row_start` behaves as in IDLE but does not clear the accumulators.
  - DRAIN: `out_valid`=1 and `out_data`=acc[idx]. Each `out_valid & out_ready` increments idx. The handshake at idx=ARRAY_SIZE-1 clears all accumulators and idx, then goes to IDLE.
- Capture arithmetic: acc[c] ← acc[c] + (sign-extend psums[c] to ACC_W) << shift. The result wraps modulo 2^ACC_W; bits shifted past ACC_W are discarded.
- `row_start` in CAPT or DRAIN is ignored. It pulses `drop` and changes no state.
- `out_data`, `out_col` and `out_last` are stable while `out_valid & !out_ready`.

## Timing
- Reset values: state IDLE, `accept`=1, `drop`=0, `out_valid`=0, `out_data`=0, `out_col`=0, `out_last`=0, all accumulators 0.
- Reset mid-CAPT or mid-DRAIN aborts immediately and loses the partial row.
- If `row_start` is seen at edge k, column c is sampled at edge k+c.
- For a last pass, `out_valid` rises in the cycle after edge k+ARRAY_SIZE-1. With `out_ready` held high, the row drains in ARRAY_SIZE cycles.
- From WAIT, back-to-back passes have zero bubble: `row_start` is legal in the first cycle of WAIT.
- All outputs are registered; there is no combinational path from `out_ready` to any output.

## Configuration
- `PSUM_SATURATE_EN` defined: each capture add saturates to the signed ACC_W range.
  - Clamp to 2^(ACC_W-1)-1 on positive overflow and to -2^(ACC_W-1) on negative overflow.
  - Overflow is detected on the shifted addend too, so shifting out significant bits saturates.
- Not defined: plain wrap modulo 2^ACC_W.

## Structure
- Shared package `systolic_pkg` holds:
  - the drain state enum (IDLE, CAPT, WAIT, DRAIN);
  - default `PSUM_W`/`ACC_W` localparams;
  - the column-index width function.
- One sub-module, `psum_shift_acc`: a single lane of sign-extend, shift, add, and optional saturation. The drain instantiates it ARRAY_SIZE times, and only the lane selected by cnt is enabled.

## Test plan
- Single pass (ARRAY_SIZE=4, shift 0, last=1): skewed psums 1, 2, 3, 4, with `out_ready` high. Expect out 1, 2, 3, 4 on cols 0–3, `out_last` on col 3, and first `out_valid` 4 cycles after `row_start`.
- Two passes: pass A psums all 3 with shift 0, then pass B psums all -1 with shift 4 and last=1. Expect every output = 3 - 16 = -13.
- Backpressure: hold `out_ready` low for 5 cycles in DRAIN. Expect `out_data`/`out_col` frozen, no skipped or duplicated columns, then IDLE after 4 handshakes.
- Protocol violation: `row_start` at cycle 2 of CAPT and again during DRAIN. Expect a `drop` pulse each time and results unchanged.
- Async `rst` low mid-CAPT: expect all outputs at their reset values within the same cycle. A following clean pass returns exactly its own psums, with no residue.
- ACC_W=40, psum 0x7FFFFFFF with shift 15 accumulated twice:
  - without `PSUM_SATURATE_EN`, expect the wrapped value;
  - with `PSUM_SATURATE_EN`, expect 0x7FFFFFFFFF.
